// File: rtl/mem_bus_master.sv
// mem_bus_master: CPU-side burst master for the multiplexed AddrData bus.
// Takes one request at a time, runs one address cycle and BURST_LEN data
// beats, then reports completion (and read data) on the response port.
module mem_bus_master #(
    parameter int DATA_W    = 16,
    parameter int BURST_LEN = 4
) (
    input  logic                        clk,
    input  logic                        resetH,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_rw,
    input  logic [DATA_W-1:0]           req_addr,
    input  logic [DATA_W*BURST_LEN-1:0] req_wdata,
    inout  tri   [DATA_W-1:0]           AddrData,
    output logic                        AddrValid,
    output logic                        rw,
    output logic                        rsp_valid,
    output logic                        rsp_rw,
    output logic [DATA_W*BURST_LEN-1:0] rsp_rdata,
    output logic                        busy
);

    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        TURN
    } state_t;

    state_t                            r_state;
    logic [BEAT_W-1:0]                 r_beat;
    logic                              r_drvEn;
    logic [DATA_W-1:0]                 r_drvData;
    logic [DATA_W*BURST_LEN-1:0]       r_wdata;
    logic [DATA_W*(BURST_LEN-1)-1:0]   r_rdBuf;

    logic                              w_lastBeat;
    logic [DATA_W*BURST_LEN-1:0]       w_rdShift;

    assign req_ready  = (r_state == IDLE) & ~resetH;
    assign AddrData   = r_drvEn ? r_drvData : 'z;
    assign w_lastBeat = (r_beat == BEAT_W'(BURST_LEN - 1));
    // Read beats arrive word 0 first, so each new word enters at the top.
    assign w_rdShift  = {AddrData, r_rdBuf};

    // Bus sequencer: every output, including the bus drive enable/value, is registered here.
    always_ff @(posedge clk) begin
        if (resetH) begin
            r_state   <= IDLE;
            r_beat    <= '0;
            r_drvEn   <= 1'b0;
            r_drvData <= '0;
            r_wdata   <= '0;
            r_rdBuf   <= '0;
            AddrValid <= 1'b0;
            rw        <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rw    <= 1'b0;
            rsp_rdata <= '0;
            busy      <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_state   <= ADDR;
                        rw        <= req_rw;
                        r_wdata   <= req_wdata;
                        r_drvData <= req_addr;
                        r_drvEn   <= 1'b1;
                        AddrValid <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                ADDR: begin
                    r_state   <= DATA;
                    r_beat    <= '0;
                    AddrValid <= 1'b0;
                    r_drvEn   <= ~rw;
                    if (!rw) begin
                        r_drvData <= r_wdata[DATA_W-1:0];
                        r_wdata   <= r_wdata >> DATA_W;
                    end
                end
                DATA: begin
                    if (rw) begin
                        r_rdBuf <= w_rdShift[DATA_W*BURST_LEN-1:DATA_W];
                    end
                    if (w_lastBeat) begin
                        r_drvEn   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rw    <= rw;
                        if (rw) begin
                            rsp_rdata <= w_rdShift;
                            r_state   <= TURN;
                        end else begin
                            r_state <= IDLE;
                            busy    <= 1'b0;
                        end
                    end else begin
                        r_beat <= r_beat + 1'b1;
                        if (!rw) begin
                            r_drvData <= r_wdata[DATA_W-1:0];
                            r_wdata   <= r_wdata >> DATA_W;
                        end
                    end
                end
                TURN: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_bus_master.md
Name: mem_bus_master

Overview:
- CPU-side bus master that drives the multiplexed AddrData bus of the memory controller. It sits directly upstream of the controller.
- Accepts one burst request at a time on a valid/ready interface. Each request is an address, a read/write flag and, for writes, four 16-bit words.
- Sequences the bus: one address cycle, then four data beats.
- Returns the read burst, or a write-completion pulse, on a response port.

Parameters:
- DATA_W, 16, width of AddrData and of each data word.
- BURST_LEN, 4, data beats per transaction. Must match the memory controller; other values are unsupported.

Ports:
- clk  input  1  clock, shared with the memory controller.
- resetH  input  1  reset; synchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  master can accept a request this cycle.
- req_rw  input  1  1 = read, 0 = write. Sampled on accept.
- req_addr  input  DATA_W  burst start address. Sampled on accept.
- req_wdata  input  DATA_W*BURST_LEN  write words; word k is at [k*DATA_W +: DATA_W]. Sampled on accept.
- AddrData  inout (tri)  DATA_W  multiplexed address/data bus.
- AddrValid  output  1  high during the address cycle only.
- rw  output  1  read/write flag to the controller. Valid during the address cycle.
- rsp_valid  output  1  one-cycle completion pulse.
- rsp_rw  output  1  type of the completed transaction.
- rsp_rdata  output  DATA_W*BURST_LEN  read burst; word k is at [k*DATA_W +: DATA_W]. Valid when rsp_valid=1 and rsp_rw=1.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (synchronous, resetH=1 at a rising edge):
  - state=IDLE, beat count=0.
  - AddrValid=0, rw=1, AddrData driver disabled (bus at z).
  - rsp_valid=0, rsp_rw=0, rsp_rdata=0, busy=0.
  - resetH takes priority over every other event.
- All outputs, including the AddrData drive enable and drive value, are registered. req_ready=(state==IDLE) & ~resetH.
- States: IDLE, ADDR, DATA, TURN.
- IDLE:
  - req_valid & req_ready at an edge latches rw, addr and wdata, then goes to ADDR.
  - The bus is not driven in IDLE.
- ADDR (exactly one cycle):
  - AddrData = latched addr, AddrValid=1, rw = latched rw.
  - Goes to DATA with beat=0.
- DATA (BURST_LEN cycles, beat 0..BURST_LEN-1):
  - AddrValid=0; rw holds its latched value.
  - Write: AddrData driven with wdata word[beat].
  - Read: AddrData released (z); the value on AddrData is captured into rsp_rdata word[beat] at the edge ending that beat.
  - At the edge ending the last beat:
    - rsp_valid=1 for the next cycle only, with rsp_rw = latched rw.
    - A write goes to IDLE.
    - A read goes to TURN.
- TURN (exactly one cycle, after reads only): bus undriven; guarantees one dead cycle between the controller's read drive and the master's next address drive. Then goes to IDLE.
- Latency:
  - Request accepted at edge T gives the ADDR cycle T..T+1 and data beats T+1..T+5.
  - rsp_valid is high in cycle T+5..T+6.
  - Minimum spacing between address cycles: 6 cycles after a write, 7 after a read.
- A request held while busy (req_ready=0) is not consumed and waits.
- rsp_rdata is held until the next read completes; writes do not modify rsp_rdata.
- Reset during ADDR, DATA or TURN: the transaction is aborted, no rsp_valid is produced, and the bus is released in the cycle after the reset edge.
- The master never drives AddrData in IDLE, TURN, or DATA of a read. A non-z value observed there is contention and is a bench error.

Test Plan:
- Write burst: req addr=0x0010, rw=0, wdata words {0xA001,0xA002,0xA003,0xA004} -> AddrData shows 0x0010 with AddrValid=1, then 0xA001..0xA004 on consecutive cycles. rsp_valid pulses once with rsp_rw=0. req_ready returns the next cycle.
- Read burst after write: read 0x0010 through the real memory controller -> AddrData is z during beats. rsp_rdata = {0xA004,0xA003,0xA002,0xA001} (word 0 in the LSBs). rsp_rw=1. One TURN cycle follows before req_ready=1.
- Back-to-back requests with req_valid held high: write 0x0020, then read 0x0020 -> address cycles 6 cycles apart. Read returns the written data. A following read is issued 7 cycles after the previous read's address cycle.
- Request while busy: req_valid asserted during DATA -> not accepted until IDLE. Exactly one transaction per accepted handshake.
- Reset mid-burst: resetH=1 during write beat 2 -> next cycle AddrValid=0 and bus z. No rsp_valid. A subsequent read of the same address completes normally.
- Bus hygiene: monitor across all scenarios -> AddrValid is never high outside ADDR, and the master's driver is never enabled in IDLE, TURN or read DATA.
